servile_timer: RTL and testbench

SERVILE_TIMER -- requirements
Module: servile_timer

---
 rtl/servile_timer_cnt.sv | 50 +++++
 rtl/servile_timer.sv | 133 +++++++++++++
 tb/tb_servile_timer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/servile_timer_cnt.sv
// Prescaler and 64-bit mtime counter. A bus write to mtime overrides the
// increment and restarts the prescale phase.
module servile_timer_cnt #(
  parameter int prescale_w = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [prescale_w-1:0] i_prescale,
  input  logic                  i_clr,
  input  logic                  i_wr,
  input  logic [63:0]           i_wr_val,
  output logic [63:0]           o_mtime
);

  logic [prescale_w-1:0] pcnt_q, pcnt_d;
  logic [63:0]           mtime_q, mtime_d;
  logic                  tick;

  assign tick = i_en & (pcnt_q == i_prescale);

  always_comb begin
    mtime_d = mtime_q + 64'(tick);
    pcnt_d  = pcnt_q;
    if (i_en) begin
      pcnt_d = tick ? '0 : pcnt_q + prescale_w'(1);
    end
    // The write value already carries the held bytes merged in by the bus side.
    if (i_wr) begin
      mtime_d = i_wr_val;
      pcnt_d  = '0;
    end
    if (i_clr) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime_q <= '0;
      pcnt_q  <= '0;
    end else begin
      mtime_q <= mtime_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign o_mtime = mtime_q;

endmodule

// File: rtl/servile_timer.sv
// RISC-V style machine timer on a minimal Wishbone responder: mtime/mtimecmp,
// prescaler, enable controls and a registered level interrupt.
module servile_timer #(
  parameter int          prescale_w = 16,
  parameter logic [63:0] reset_cmp  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_timer_irq
);

  localparam logic [2:0] ADR_MTIME_LO    = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI    = 3'd1;
  localparam logic [2:0] ADR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] ADR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] ADR_CTRL        = 3'd4;
  localparam logic [2:0] ADR_PRESCALE    = 3'd5;
  localparam int         CTRL_EN         = 0;
  localparam int         CTRL_IRQ_EN     = 1;

  logic                  ack_q;
  logic [31:0]           rdt_q;
  logic                  irq_q;
  logic [31:0]           shadow_q;
  logic [63:0]           cmp_q;
  logic [1:0]            ctrl_q;
  logic [prescale_w-1:0] pre_q;

  logic [2:0]  adr;
  logic        access, wr, rd;
  logic        wr_mtime, wr_pre;
  logic [63:0] mtime;
  logic [63:0] mtime_wr_val;
  logic [31:0] rdata;
  logic        unused_adr;

  function automatic logic [31:0] merge32(input logic [31:0] old,
                                          input logic [31:0] dat,
                                          input logic [3:0]  sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = dat[b*8 +: 8];
    end
    return r;
  endfunction

  assign adr        = i_wb_adr[4:2];
  assign unused_adr = ^{i_wb_adr[31:5], i_wb_adr[1:0]};

  // A new access is taken only when no ack is outstanding, so ack never repeats.
  assign access   = i_wb_stb & ~ack_q;
  assign wr       = access & i_wb_we;
  assign rd       = access & ~i_wb_we;
  assign wr_mtime = wr & ((adr == ADR_MTIME_LO) | (adr == ADR_MTIME_HI));
  assign wr_pre   = wr & (adr == ADR_PRESCALE);

  always_comb begin
    mtime_wr_val = mtime;
    if (adr == ADR_MTIME_LO) begin
      mtime_wr_val[31:0] = merge32(mtime[31:0], i_wb_dat, i_wb_sel);
    end else begin
      mtime_wr_val[63:32] = merge32(mtime[63:32], i_wb_dat, i_wb_sel);
    end
  end

  servile_timer_cnt #(
    .prescale_w(prescale_w)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (ctrl_q[CTRL_EN]),
    .i_prescale (pre_q),
    .i_clr      (wr_pre),
    .i_wr       (wr_mtime),
    .i_wr_val   (mtime_wr_val),
    .o_mtime    (mtime)
  );

  always_comb begin
    rdata = '0;
    case (adr)
      ADR_MTIME_LO:    rdata = mtime[31:0];
      ADR_MTIME_HI:    rdata = shadow_q;
      ADR_MTIMECMP_LO: rdata = cmp_q[31:0];
      ADR_MTIMECMP_HI: rdata = cmp_q[63:32];
      ADR_CTRL:        rdata = {30'd0, ctrl_q};
      ADR_PRESCALE:    rdata = 32'(pre_q);
      default:         rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q    <= 1'b0;
      rdt_q    <= '0;
      irq_q    <= 1'b0;
      shadow_q <= '0;
      cmp_q    <= reset_cmp;
      ctrl_q   <= 2'b01;
      pre_q    <= '0;
    end else begin
      ack_q <= access;
      rdt_q <= rd ? rdata : 32'd0;
      irq_q <= ctrl_q[CTRL_IRQ_EN] & (mtime >= cmp_q);
      // Snapshot the high word so a LO-then-HI read pair is coherent.
      if (rd && (adr == ADR_MTIME_LO)) begin
        shadow_q <= mtime[63:32];
      end
      if (wr) begin
        case (adr)
          ADR_MTIMECMP_LO: cmp_q[31:0]  <= merge32(cmp_q[31:0], i_wb_dat, i_wb_sel);
          ADR_MTIMECMP_HI: cmp_q[63:32] <= merge32(cmp_q[63:32], i_wb_dat, i_wb_sel);
          ADR_CTRL:        if (i_wb_sel[0]) ctrl_q <= i_wb_dat[1:0];
          ADR_PRESCALE:    pre_q <= prescale_w'(merge32(32'(pre_q), i_wb_dat, i_wb_sel));
          default:         ;
        endcase
      end
    end
  end

  assign o_wb_ack    = ack_q;
  assign o_wb_rdt    = rdt_q;
  assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_servile_timer.sv
// Self-checking bench for servile_timer: directed scenarios plus random bus
// traffic, all compared against a behavioural model of the timer.
module tb_servile_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, stb;
  logic [31:0] rdt;
  logic        ack, irq;
  logic        mon = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  servile_timer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wb_adr    (adr),
    .i_wb_dat    (dat),
    .i_wb_sel    (sel),
    .i_wb_we     (we),
    .i_wb_stb    (stb),
    .o_wb_rdt    (rdt),
    .o_wb_ack    (ack),
    .o_timer_irq (irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference model
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_pcnt, m_pre, m_shadow, m_rdt;
  logic [1:0]  m_ctrl;
  logic        m_ack, m_irq;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_shadow;
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {30'd0, m_ctrl};
      3'd5:    return m_pre;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic        acc, wacc, tick, nirq;
    logic [2:0]  a;
    logic [63:0] nt;
    if (rst) begin
      m_mtime = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_pcnt = 0; m_pre = 0;
      m_shadow = 0; m_rdt = 0; m_ctrl = 2'b01; m_ack = 0; m_irq = 0;
    end else begin
      a    = adr[4:2];
      acc  = stb && !m_ack;
      wacc = acc && we;
      nirq = m_ctrl[1] && (m_mtime >= m_cmp);
      m_rdt = (acc && !we) ? m_read(a) : 32'd0;
      if (acc && !we && a == 3'd0) m_shadow = m_mtime[63:32];
      tick = m_ctrl[0] && (m_pcnt == m_pre);
      if (m_ctrl[0]) m_pcnt = tick ? 0 : m_pcnt + 1;
      nt = tick ? m_mtime + 64'd1 : m_mtime;
      if (wacc) begin
        case (a)
          3'd0: begin nt = {m_mtime[63:32], bmerge(m_mtime[31:0], dat, sel)}; m_pcnt = 0; end
          3'd1: begin nt = {bmerge(m_mtime[63:32], dat, sel), m_mtime[31:0]}; m_pcnt = 0; end
          3'd2: m_cmp[31:0]  = bmerge(m_cmp[31:0], dat, sel);
          3'd3: m_cmp[63:32] = bmerge(m_cmp[63:32], dat, sel);
          3'd4: if (sel[0]) m_ctrl = dat[1:0];
          3'd5: begin m_pre = bmerge(m_pre, dat, sel) & 32'h0000_FFFF; m_pcnt = 0; end
          default: ;
        endcase
      end
      m_mtime = nt;
      m_irq   = nirq;
      m_ack   = acc;
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      check("ack", ack, m_ack);
      check("rdt", rdt, m_rdt);
      check("irq", irq, m_irq);
    end
  end

  // Bus access starting at a negedge; returns at the negedge where ack is seen.
  task automatic bus(input logic [2:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r, output int cyc);
    adr = $urandom;
    adr[4:2] = a;
    we = w; dat = d; sel = s; stb = 1'b1;
    cyc = 0;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack) break;
      cyc++;
    end
    check("ack_seen", ack, 1'b1);
    r = rdt;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    int c;
    bus(a, 1'b1, d, s, r, c);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] r);
    int c;
    bus(a, 1'b0, 32'd0, 4'h0, r, c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    int          c, k;
    rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon = 1'b1;
    check("irq_reset", irq, 1'b0);
    check("ack_reset", ack, 1'b0);

    bus(3'd4, 1'b0, 32'd0, 4'h0, r, c);
    check("ctrl_reset", r, 32'h1);
    check("ack_latency", c, 0);
    @(negedge clk);
    check("ack_single", ack, 1'b0);
    rd(3'd5, r); check("prescale_reset", r, 32'h0);
    rd(3'd3, r); check("cmp_hi_reset", r, 32'hFFFF_FFFF);

    wr(3'd2, 32'hAABB_CCDD, 4'b0010);
    rd(3'd2, r); check("cmp_lo_bytesel", r, 32'hFFFF_CCFF);

    // Prescaler divide-by-4
    wr(3'd4, 32'h0, 4'hF);
    wr(3'd0, 32'h0, 4'hF);
    wr(3'd1, 32'h0, 4'hF);
    wr(3'd5, 32'h3, 4'hF);
    wr(3'd4, 32'h1, 4'hF);
    repeat (40) @(negedge clk);
    rd(3'd0, r); check("prescale3_mtime", r, 32'd10);

    // Carry into high word, read through shadow
    wr(3'd4, 32'h0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(3'd1, 32'h0000_0001, 4'hF);
    wr(3'd5, 32'h0, 4'hF);
    wr(3'd4, 32'h1, 4'hF);
    rd(3'd0, r); check("carry_lo", r, 32'h0);
    rd(3'd1, r); check("carry_hi_shadow", r, 32'h2);

    // Full 64-bit wrap
    wr(3'd4, 32'h0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(3'd1, 32'hFFFF_FFFF, 4'hF);
    wr(3'd4, 32'h1, 4'hF);
    rd(3'd0, r); check("wrap_lo", r, 32'h0);
    rd(3'd1, r); check("wrap_hi", r, 32'h0);

    // Unmapped location
    wr(3'd6, 32'h1234_5678, 4'hF);
    rd(3'd6, r); check("unmapped_rd", r, 32'h0);
    rd(3'd7, r); check("unmapped7_rd", r, 32'h0);

    // Compare and interrupt
    wr(3'd4, 32'h0, 4'hF);
    wr(3'd3, 32'h0, 4'hF);
    wr(3'd2, 32'd100, 4'hF);
    wr(3'd0, 32'h0, 4'hF);
    wr(3'd1, 32'h0, 4'hF);
    wr(3'd4, 32'h3, 4'hF);
    k = 0;
    while (m_mtime < 64'd100 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("reach_100", m_mtime, 64'd100);
    check("irq_pre", irq, 1'b0);
    @(negedge clk);
    check("irq_rise", irq, 1'b1);
    wr(3'd2, 32'd1000, 4'hF);
    check("irq_hold", irq, 1'b1);
    @(negedge clk);
    check("irq_clear", irq, 1'b0);

    // Reset in the middle of a pending access
    adr = 32'h0000_0010; we = 1'b0; stb = 1'b1; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ack_in_reset", ack, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("ack_after_reset", ack, 1'b1);
    check("ctrl_after_reset", rdt, 32'h1);
    stb = 1'b0;
    @(negedge clk);
    check("ack_drop", ack, 1'b0);
    rd(3'd0, r);
    check("mtime_small", (r <= 32'd8), 1'b1);
    rd(3'd2, r); check("cmp_after_reset", r, 32'hFFFF_FFFF);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  a;
      logic        w;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      w = 1'($urandom);
      d = $urandom;
      if (a == 3'd5) d = $urandom_range(0, 3);
      if (a == 3'd3 && w) d = $urandom_range(0, 1) == 0 ? 32'h0 : d;
      bus(a, w, d, 4'($urandom), r, c);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    mon = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
